uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Buffered UART transmitter. It accepts bytes from the CPU-side bus wrapper through a write strobe, queues them in a small FIFO, and serializes them onto `uart_txd` as 8N1 frames (optionally 8E1). It sits between the memory-mapped UART wrapper's data-register write path and the TX pin, so the CPU can burst several bytes without polling busy per byte.

## Interface
- `CLK_HZ`, default 1_000_000: system clock frequency.
- `BIT_RATE`, default 115200: line bit rate. `CPB = CLK_HZ / BIT_RATE` uses integer division (8 at the defaults). `CPB` ≥ 2 is required.
- `PAYLOAD_BITS`, default 8: data bits per frame.
- `FIFO_DEPTH`, default 4: queue entries. Must be a power of 2 and ≥ 2.
- `clk`  in  1  system clock.
- `resetn`  in  1  reset: synchronous, active-low.
- `tx_data`  in  PAYLOAD_BITS  byte to enqueue.
- `tx_en`  in  1  write strobe. Enqueues `tx_data` on each rising edge where it is high.
- `ovf_clr`  in  1  clears the sticky overflow flag.
- `uart_txd`  out  1  serial output, registered, idle high.
- `tx_busy`  out  1  high when the FIFO is non-empty or a frame is in progress.
- `tx_full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `tx_empty`  out  1  FIFO holds 0 entries.
- `tx_count`  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- `tx_ovf`  out  1  sticky: a write was dropped because the FIFO was full.

## Operation
- FIFO
  - Circular buffer with read/write pointers and an occupancy counter.
  - A write is accepted when `tx_en` is high and `tx_full` is low (pre-edge value).
  - A write while full is dropped, sets `tx_ovf`, and leaves the FIFO unchanged. This holds even if a pop occurs on the same edge.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - Simultaneous accepted write and pop: `tx_count` is unchanged.
- `tx_ovf` clear
  - `ovf_clr` clears `tx_ovf`.
  - If an overflow and `ovf_clr` occur on the same edge, set wins.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE
  - If the FIFO is non-empty: pop the head into the shift register, drive `uart_txd` = 0, load the bit counter with `CPB-1`, go to START.
  - Otherwise hold `uart_txd` = 1.
- START: after `CPB` cycles, drive bit 0 and go to DATA.
- DATA
  - Shifts LSB first. Each bit is held `CPB` cycles.
  - After bit `PAYLOAD_BITS-1`, go to PARITY (macro only) or STOP, driving the corresponding bit.
- STOP
  - Holds `uart_txd` = 1 for `CPB` cycles.
  - At the end, if the FIFO is non-empty, pop and go directly to START, so there is no idle gap between frames. Otherwise go to IDLE.
- `tx_busy` = (state != IDLE) | ~`tx_empty`.
- Reset mid-frame (`resetn` low at any edge):
  - `uart_txd` returns to 1 after that edge.
  - FIFO is emptied.
  - State goes to IDLE, `tx_ovf` = 0.
  - The partial frame is abandoned.

## Timing
- Reset values: `uart_txd` = 1, `tx_busy` = 0, `tx_full` = 0, `tx_empty` = 1, `tx_count` = 0, `tx_ovf` = 0.
- Write accepted at edge E0:
  - `tx_count` and `tx_empty` update after E0.
  - If IDLE, the FSM pops at edge E1, and `uart_txd` falls after E1.
  - Write-to-start-bit latency is 1 cycle.
- Frame length:
  - 10·`CPB` cycles (80 at the defaults).
  - 11·`CPB` with parity enabled.
- Back-to-back frames: the next start bit begins the cycle immediately after the last stop-bit cycle.
- `tx_busy` falls on the edge that moves the FSM to IDLE with the FIFO empty.
- Status outputs are registered or derived from registers only. There are no combinational paths from inputs to outputs.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state is compiled in.
  - After the data bits, one even-parity bit (XOR of the payload) is sent for `CPB` cycles.
  - Frame is 8E1.
- `UART_TX_PARITY_EN` undefined:
  - The PARITY state and logic are absent.
  - DATA goes directly to STOP.
  - Frame is 8N1.

## Test plan
- Reset, then pulse `tx_en` with 0x55 at edge E0:
  - `uart_txd` is low for cycles E1..E1+7.
  - Then 1,0,1,0,1,0,1,0 at 8 cycles each.
  - Then high for 8 cycles.
  - `tx_busy` falls 81 cycles after E0.
- Write 0xA5, 0x3C, 0xFF on consecutive cycles: three frames are sent with no idle gap between stop and next start, and the decoded bytes match in order.
- With the FIFO full (4 writes while the first is still queued), write a 5th byte 0x99:
  - `tx_ovf` = 1.
  - 0x99 is never transmitted.
  - `ovf_clr` pulse clears `tx_ovf`.
- Assert `tx_en` on the same edge the STOP state pops the head while `tx_count` = 4: the write is dropped, `tx_ovf` is set, and `tx_count` goes to 3.
- Assert `resetn` low during DATA bit 3 of 0x0F with 2 bytes queued: after that edge `uart_txd` = 1, `tx_count` = 0, and `tx_busy` = 0, and no further frames are sent.
- With `UART_TX_PARITY_EN` defined, send 0x07: the parity bit is 1, the frame is 88 cycles long, and the stop bit follows the parity bit.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_if
//
// Purpose:
//   Groups the CPU-side write path and the TX status/serial outputs of the
//   buffered UART transmitter into one bundle. The bus wrapper (or a
//   testbench) connects through the master modport. The transmitter itself
//   uses the slave modport.
//
// Parameters:
//   PAYLOAD_BITS  data bits per frame (width of tx_data)
//   FIFO_DEPTH    queue entries (sets the width of tx_count)
//
// Signals:
//   tx_data   master->slave  byte to enqueue
//   tx_en     master->slave  write strobe, one enqueue per high clock edge
//   ovf_clr   master->slave  clears the sticky overflow flag
//   uart_txd  slave->master  serial line, idle high
//   tx_busy   slave->master  FIFO non-empty or frame in progress
//   tx_full   slave->master  FIFO holds FIFO_DEPTH entries
//   tx_empty  slave->master  FIFO holds no entries
//   tx_count  slave->master  FIFO occupancy
//   tx_ovf    slave->master  sticky: a write was dropped while full
// ---------------------------------------------------------------------------
interface uart_tx_fifo_if #(
    parameter int PAYLOAD_BITS = 8,
    parameter int FIFO_DEPTH   = 4
);
    logic [PAYLOAD_BITS-1:0]          tx_data;
    logic                             tx_en;
    logic                             ovf_clr;
    logic                             uart_txd;
    logic                             tx_busy;
    logic                             tx_full;
    logic                             tx_empty;
    logic [$clog2(FIFO_DEPTH+1)-1:0]  tx_count;
    logic                             tx_ovf;

    modport master (
        output tx_data,
        output tx_en,
        output ovf_clr,
        input  uart_txd,
        input  tx_busy,
        input  tx_full,
        input  tx_empty,
        input  tx_count,
        input  tx_ovf
    );

    modport slave (
        input  tx_data,
        input  tx_en,
        input  ovf_clr,
        output uart_txd,
        output tx_busy,
        output tx_full,
        output tx_empty,
        output tx_count,
        output tx_ovf
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//
// Purpose:
//   Buffered UART transmitter. Bytes written through the bus strobe are
//   queued in a small circular FIFO and serialized LSB first onto uart_txd
//   as 8N1 frames. When a stop bit ends and another byte is waiting, the
//   next start bit follows immediately with no idle gap.
//
// Optional feature:
//   Define UART_TX_PARITY_EN to add an even-parity bit after the data bits
//   (8E1). When the macro is undefined, the PARITY state and its logic are
//   not built and the frame is 8N1.
//
// Parameters:
//   CLK_HZ        system clock frequency
//   BIT_RATE      line bit rate; CPB = CLK_HZ / BIT_RATE, must be >= 2
//   PAYLOAD_BITS  data bits per frame
//   FIFO_DEPTH    queue entries, power of two, >= 2
//
// Ports:
//   clk     system clock
//   resetn  synchronous, active-low reset
//   bus     uart_tx_fifo_if slave: tx_data/tx_en/ovf_clr in;
//           uart_txd/tx_busy/tx_full/tx_empty/tx_count/tx_ovf out
//
// Every output comes straight from a register or from logic on registers
// only, so there is no combinational path from the inputs to the outputs.
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLK_HZ       = 1_000_000,
    parameter int BIT_RATE     = 115200,
    parameter int PAYLOAD_BITS = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic          clk,
    input  logic          resetn,
    uart_tx_fifo_if.slave bus
);

    localparam int CPB    = CLK_HZ / BIT_RATE;
    localparam int CNT_W  = (CPB > 2) ? $clog2(CPB) : 1;
    localparam int IDX_W  = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] CPB_M1    = CNT_W'(CPB - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PAYLOAD_BITS - 1);
    localparam logic [OCC_W-1:0] FULL_CNT  = OCC_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;
`endif

    // FIFO storage and bookkeeping
    logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]        count_q,  count_d;
    logic                    ovf_q,    ovf_d;

    // Serializer state
    state_t                  state_q,  state_d;
    logic [CNT_W-1:0]        cnt_q,    cnt_d;
    logic [IDX_W-1:0]        idx_q,    idx_d;
    logic [PAYLOAD_BITS-1:0] shift_q,  shift_d;
    logic                    txd_q,    txd_d;
`ifdef UART_TX_PARITY_EN
    logic                    par_q,    par_d;
`endif

    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    logic [PAYLOAD_BITS-1:0] head;

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];

    // The full check uses the pre-edge occupancy, so a write arriving while
    // full is dropped even if the serializer pops on the same edge.
    assign push       = bus.tx_en & ~fifo_full;

    // FIFO next-state: pointer advance, occupancy and the sticky overflow.
    // Pointers wrap for free because FIFO_DEPTH is a power of two. For the
    // overflow flag the set test comes after the clear so set wins.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase

        if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (bus.tx_en && fifo_full) begin
            ovf_d = 1'b1;
        end
    end

    // Serializer next-state and line output. The bit counter is loaded
    // with CPB-1 on entry to each bit and the bit ends when it reaches
    // zero, so every bit lasts exactly CPB cycles. A pop loads the head
    // into the shift register and drives the start bit on the same edge.
    // That edge is either the first edge in IDLE with data waiting or the
    // last edge of STOP, which is what removes the gap between frames.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        txd_d   = txd_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^head;
`endif
                    txd_d   = 1'b0;
                    cnt_d   = CPB_M1;
                    state_d = START;
                end
            end

            START: begin
                if (cnt_q == '0) begin
                    txd_d   = shift_q[0];
                    cnt_d   = CPB_M1;
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = CPB_M1;
                    if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        txd_d   = par_q;
                        state_d = PARITY;
`else
                        txd_d   = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        shift_d = shift_q >> 1;
                        txd_d   = shift_d[0];
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (cnt_q == '0) begin
                    txd_d   = 1'b1;
                    cnt_d   = CPB_M1;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif

            STOP: begin
                if (cnt_q == '0) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = head;
`ifdef UART_TX_PARITY_EN
                        par_d   = ^head;
`endif
                        txd_d   = 1'b0;
                        cnt_d   = CPB_M1;
                        state_d = START;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                txd_d   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // Control and status registers. Reset abandons any partial frame,
    // empties the FIFO, clears the overflow flag and returns the line high.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    // FIFO storage has no reset; entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.tx_data;
        end
    end

    assign bus.uart_txd = txd_q;
    assign bus.tx_busy  = (state_q != IDLE) | ~fifo_empty;
    assign bus.tx_full  = fifo_full;
    assign bus.tx_empty = fifo_empty;
    assign bus.tx_count = count_q;
    assign bus.tx_ovf   = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Directed testbench for uart_tx_fifo at the default parameters (CPB = 8).
// Inputs are driven 1 ns after each rising edge. The serial line and busy
// flag are captured on every falling edge into a ring buffer so each
// scenario can compare whole frames against a bit-level model afterwards.
// Builds with or without UART_TX_PARITY_EN; the frame model follows it.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int CLK_HZ   = 1_000_000;
    localparam int BIT_RATE = 115200;
    localparam int PB       = 8;
    localparam int DEPTH    = 4;
    localparam int CPB      = CLK_HZ / BIT_RATE;
`ifdef UART_TX_PARITY_EN
    localparam int SLOTS    = 11;
`else
    localparam int SLOTS    = 10;
`endif
    localparam int FRAME    = CPB * SLOTS;
    localparam int OBS_N    = 4096;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.PAYLOAD_BITS(PB), .FIFO_DEPTH(DEPTH)) bus ();

    uart_tx_fifo #(
        .CLK_HZ      (CLK_HZ),
        .BIT_RATE    (BIT_RATE),
        .PAYLOAD_BITS(PB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Falling-edge capture of the line and busy flag
    logic obs_txd  [OBS_N];
    logic obs_busy [OBS_N];
    int   neg_idx = 0;

    always @(negedge clk) begin
        obs_txd[neg_idx % OBS_N]  <= bus.uart_txd;
        obs_busy[neg_idx % OBS_N] <= bus.tx_busy;
        neg_idx                   <= neg_idx + 1;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected line level k cycles after the start bit begins
    function automatic logic exp_bit(input logic [PB-1:0] b, input int k);
        int slot;
        slot = k / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= PB) return b[slot-1];
`ifdef UART_TX_PARITY_EN
        if (slot == PB + 1) return ^b;
`endif
        return 1'b1;
    endfunction

    function automatic logic txd_at(input int base, input int j);
        return obs_txd[(base + j) % OBS_N];
    endfunction

    function automatic logic busy_at(input int base, input int j);
        return obs_busy[(base + j) % OBS_N];
    endfunction

    function automatic int frame_errs(input int base, input int start, input logic [PB-1:0] b);
        int n;
        n = 0;
        for (int k = 0; k < FRAME; k++) begin
            if (txd_at(base, start + k) !== exp_bit(b, k)) n++;
        end
        return n;
    endfunction

    function automatic logic [PB-1:0] decode(input int base, input int start);
        logic [PB-1:0] v;
        v = '0;
        for (int i = 0; i < PB; i++) begin
            v[i] = txd_at(base, start + CPB * (i + 1) + CPB / 2);
        end
        return v;
    endfunction

    task automatic run_until(input int base, input int samples);
        for (int g = 0; g < 20000 && (neg_idx - base) < samples; g++) step();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) step();
        total++; if (bus.uart_txd !== 1'b1) begin bad++; $display("[TB] FAIL reset_txd: got %b want 1", bus.uart_txd); end
        total++; if (bus.tx_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", bus.tx_busy); end
        total++; if (bus.tx_full !== 1'b0) begin bad++; $display("[TB] FAIL reset_full: got %b want 0", bus.tx_full); end
        total++; if (bus.tx_empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty: got %b want 1", bus.tx_empty); end
        total++; if (bus.tx_count !== 3'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d want 0", bus.tx_count); end
        total++; if (bus.tx_ovf !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf: got %b want 0", bus.tx_ovf); end
        resetn = 1'b1;
        step();
    endtask

    task automatic test_single();
        int base;
        int errs;
        bus.tx_data = 8'h55;
        bus.tx_en   = 1'b1;
        step();
        bus.tx_en = 1'b0;
        base = neg_idx;
        total++; if (bus.tx_count !== 3'd1) begin bad++; $display("[TB] FAIL single_count: got %0d want 1", bus.tx_count); end
        total++; if (bus.tx_empty !== 1'b0) begin bad++; $display("[TB] FAIL single_empty: got %b want 0", bus.tx_empty); end
        total++; if (bus.tx_busy !== 1'b1) begin bad++; $display("[TB] FAIL single_busy: got %b want 1", bus.tx_busy); end
        run_until(base, FRAME + 2);
        total++; if (txd_at(base, 0) !== 1'b1) begin bad++; $display("[TB] FAIL single_prestart: got %b want 1", txd_at(base, 0)); end
        errs = frame_errs(base, 1, 8'h55);
        total++; if (errs !== 0) begin bad++; $display("[TB] FAIL single_frame: wrong cycles %0d want 0", errs); end
        total++; if (busy_at(base, FRAME) !== 1'b1) begin bad++; $display("[TB] FAIL single_busy_last: got %b want 1", busy_at(base, FRAME)); end
        total++; if (busy_at(base, FRAME + 1) !== 1'b0) begin bad++; $display("[TB] FAIL single_busy_fall: got %b want 0", busy_at(base, FRAME + 1)); end
        total++; if (txd_at(base, FRAME + 1) !== 1'b1) begin bad++; $display("[TB] FAIL single_idle: got %b want 1", txd_at(base, FRAME + 1)); end
    endtask

    task automatic test_back_to_back();
        logic [PB-1:0] bytes [3];
        logic [PB-1:0] got;
        int base;
        int errs;
        bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'hFF;
        bus.tx_data = bytes[0];
        bus.tx_en   = 1'b1;
        step();
        base = neg_idx;
        bus.tx_data = bytes[1];
        step();
        bus.tx_data = bytes[2];
        step();
        bus.tx_en = 1'b0;
        run_until(base, 3 * FRAME + 2);
        for (int f = 0; f < 3; f++) begin
            errs = frame_errs(base, 1 + f * FRAME, bytes[f]);
            total++; if (errs !== 0) begin bad++; $display("[TB] FAIL b2b_frame%0d: wrong cycles %0d want 0", f, errs); end
            got = decode(base, 1 + f * FRAME);
            total++; if (got !== bytes[f]) begin bad++; $display("[TB] FAIL b2b_byte%0d: got %h want %h", f, got, bytes[f]); end
        end
        total++; if (busy_at(base, 3 * FRAME + 1) !== 1'b0) begin bad++; $display("[TB] FAIL b2b_busy_end: got %b want 0", busy_at(base, 3 * FRAME + 1)); end
    endtask

    task automatic test_overflow();
        logic [PB-1:0] wr [6];
        logic [PB-1:0] got;
        int base;
        int idle_errs;
        wr[0] = 8'h11; wr[1] = 8'h22; wr[2] = 8'h33;
        wr[3] = 8'h44; wr[4] = 8'h55; wr[5] = 8'h99;
        bus.tx_data = wr[0];
        bus.tx_en   = 1'b1;
        step();
        base = neg_idx;
        for (int i = 1; i < 6; i++) begin
            bus.tx_data = wr[i];
            step();
            if (i == 4) begin
                total++; if (bus.tx_full !== 1'b1) begin bad++; $display("[TB] FAIL ovf_full: got %b want 1", bus.tx_full); end
                total++; if (bus.tx_count !== 3'd4) begin bad++; $display("[TB] FAIL ovf_count_full: got %0d want 4", bus.tx_count); end
                total++; if (bus.tx_ovf !== 1'b0) begin bad++; $display("[TB] FAIL ovf_early: got %b want 0", bus.tx_ovf); end
            end
        end
        bus.tx_en = 1'b0;
        total++; if (bus.tx_ovf !== 1'b1) begin bad++; $display("[TB] FAIL ovf_set: got %b want 1", bus.tx_ovf); end
        total++; if (bus.tx_count !== 3'd4) begin bad++; $display("[TB] FAIL ovf_count_kept: got %0d want 4", bus.tx_count); end
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        total++; if (bus.tx_ovf !== 1'b0) begin bad++; $display("[TB] FAIL ovf_clear: got %b want 0", bus.tx_ovf); end
        // overflow and clear on the same edge: set must win
        bus.tx_data = 8'h99;
        bus.tx_en   = 1'b1;
        bus.ovf_clr = 1'b1;
        step();
        bus.tx_en   = 1'b0;
        bus.ovf_clr = 1'b0;
        total++; if (bus.tx_ovf !== 1'b1) begin bad++; $display("[TB] FAIL ovf_set_wins: got %b want 1", bus.tx_ovf); end
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        total++; if (bus.tx_ovf !== 1'b0) begin bad++; $display("[TB] FAIL ovf_clear2: got %b want 0", bus.tx_ovf); end
        run_until(base, 5 * FRAME + 22);
        for (int f = 0; f < 5; f++) begin
            got = decode(base, 1 + f * FRAME);
            total++; if (got !== wr[f]) begin bad++; $display("[TB] FAIL ovf_byte%0d: got %h want %h", f, got, wr[f]); end
        end
        idle_errs = 0;
        for (int j = 5 * FRAME + 1; j < 5 * FRAME + 22; j++) begin
            if (txd_at(base, j) !== 1'b1) idle_errs++;
        end
        total++; if (idle_errs !== 0) begin bad++; $display("[TB] FAIL ovf_no_sixth: low cycles %0d want 0", idle_errs); end
        total++; if (busy_at(base, 5 * FRAME + 1) !== 1'b0) begin bad++; $display("[TB] FAIL ovf_busy_end: got %b want 0", busy_at(base, 5 * FRAME + 1)); end
    endtask

    task automatic test_pop_collision();
        logic [PB-1:0] wr [5];
        logic [PB-1:0] got;
        int base;
        int errs;
        wr[0] = 8'h11; wr[1] = 8'h22; wr[2] = 8'h33; wr[3] = 8'h44; wr[4] = 8'h55;
        bus.tx_data = wr[0];
        bus.tx_en   = 1'b1;
        step();
        base = neg_idx;
        for (int i = 1; i < 5; i++) begin
            bus.tx_data = wr[i];
            step();
        end
        bus.tx_en = 1'b0;
        // park just before the edge where STOP of frame 0 pops the next byte
        run_until(base, FRAME);
        total++; if (bus.tx_count !== 3'd4) begin bad++; $display("[TB] FAIL coll_pre_count: got %0d want 4", bus.tx_count); end
        bus.tx_data = 8'h77;
        bus.tx_en   = 1'b1;
        step();
        bus.tx_en = 1'b0;
        total++; if (bus.tx_count !== 3'd3) begin bad++; $display("[TB] FAIL coll_count: got %0d want 3", bus.tx_count); end
        total++; if (bus.tx_ovf !== 1'b1) begin bad++; $display("[TB] FAIL coll_ovf: got %b want 1", bus.tx_ovf); end
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        run_until(base, 5 * FRAME + 2);
        for (int f = 0; f < 5; f++) begin
            errs = frame_errs(base, 1 + f * FRAME, wr[f]);
            got  = decode(base, 1 + f * FRAME);
            total++; if (errs !== 0 || got !== wr[f]) begin bad++; $display("[TB] FAIL coll_frame%0d: got %h (%0d wrong cycles) want %h", f, got, errs, wr[f]); end
        end
        total++; if (busy_at(base, 5 * FRAME + 1) !== 1'b0) begin bad++; $display("[TB] FAIL coll_busy_end: got %b want 0", busy_at(base, 5 * FRAME + 1)); end
    endtask

    task automatic test_reset_mid();
        int base;
        int base2;
        int idle_errs;
        int busy_errs;
        bus.tx_data = 8'h0F;
        bus.tx_en   = 1'b1;
        step();
        base = neg_idx;
        bus.tx_data = 8'hAA;
        step();
        bus.tx_data = 8'hBB;
        step();
        bus.tx_en = 1'b0;
        total++; if (bus.tx_count !== 3'd2) begin bad++; $display("[TB] FAIL rmid_queued: got %0d want 2", bus.tx_count); end
        // middle of data bit 3
        run_until(base, 4 * CPB + CPB / 2);
        total++; if (bus.tx_busy !== 1'b1) begin bad++; $display("[TB] FAIL rmid_busy_pre: got %b want 1", bus.tx_busy); end
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        total++; if (bus.uart_txd !== 1'b1) begin bad++; $display("[TB] FAIL rmid_txd: got %b want 1", bus.uart_txd); end
        total++; if (bus.tx_count !== 3'd0) begin bad++; $display("[TB] FAIL rmid_count: got %0d want 0", bus.tx_count); end
        total++; if (bus.tx_busy !== 1'b0) begin bad++; $display("[TB] FAIL rmid_busy: got %b want 0", bus.tx_busy); end
        total++; if (bus.tx_empty !== 1'b1) begin bad++; $display("[TB] FAIL rmid_empty: got %b want 1", bus.tx_empty); end
        base2 = neg_idx;
        run_until(base2, 3 * FRAME);
        idle_errs = 0;
        busy_errs = 0;
        for (int j = 0; j < 3 * FRAME; j++) begin
            if (txd_at(base2, j) !== 1'b1) idle_errs++;
            if (busy_at(base2, j) !== 1'b0) busy_errs++;
        end
        total++; if (idle_errs !== 0) begin bad++; $display("[TB] FAIL rmid_no_frames: low cycles %0d want 0", idle_errs); end
        total++; if (busy_errs !== 0) begin bad++; $display("[TB] FAIL rmid_stays_idle: busy cycles %0d want 0", busy_errs); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int base;
        int errs;
        bus.tx_data = 8'h07;
        bus.tx_en   = 1'b1;
        step();
        bus.tx_en = 1'b0;
        base = neg_idx;
        run_until(base, FRAME + 2);
        total++; if (txd_at(base, 1 + 9 * CPB + CPB / 2) !== 1'b1) begin bad++; $display("[TB] FAIL par_bit: got %b want 1", txd_at(base, 1 + 9 * CPB + CPB / 2)); end
        errs = frame_errs(base, 1, 8'h07);
        total++; if (errs !== 0) begin bad++; $display("[TB] FAIL par_frame: wrong cycles %0d want 0", errs); end
        total++; if (busy_at(base, 88) !== 1'b1 || busy_at(base, 89) !== 1'b0) begin bad++; $display("[TB] FAIL par_length: busy %b%b want 10", busy_at(base, 88), busy_at(base, 89)); end
    endtask
`endif

    initial begin
        bus.tx_data = '0;
        bus.tx_en   = 1'b0;
        bus.ovf_clr = 1'b0;
        $display("[TB] uart_tx_fifo bench, CPB=%0d frame=%0d cycles", CPB, FRAME);
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_pop_collision();
        test_reset_mid();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
